// File: rtl/scs8hd_o31a_pipe.sv
// NCH-channel (|A)&B1 evaluator behind a DEPTH-stage valid/ready pipeline with bubble collapse,
// plus a sticky hit accumulator and a saturating hit-beat counter on the output handshake.
module scs8hd_o31a_pipe #(
  parameter int NCH   = 4,
  parameter int NA    = 3,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH*NA-1:0] A,
  input  logic [NCH-1:0]    B1,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NCH-1:0]    X,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr,
  output logic [NCH-1:0]    acc,
  output logic [CW-1:0]     hit_cnt
);

  logic [NCH-1:0] f;
  logic           fire;
  logic [NCH-1:0] acc_nxt;
  logic [CW-1:0]  hit_base;
  logic [CW-1:0]  hit_nxt;

  always_comb begin
    f = '0;
    for (int c = 0; c < NCH; c++) f[c] = (|A[c*NA +: NA]) & B1[c];
  end

  generate
    if (DEPTH == 0) begin : g_comb
      assign X         = f;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
    end else begin : g_pipe
      logic [DEPTH-1:0] v;
      logic [DEPTH-1:0] rdy;
      logic [NCH-1:0]   d [DEPTH];
      logic             run;

      // A stage may load when it or any stage downstream of it has room, or the sink drains.
      always_comb begin
        rdy = '0;
        run = out_ready;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          run    = run | !v[s];
          rdy[s] = run;
        end
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          v <= '0;
          for (int s = 0; s < DEPTH; s++) d[s] <= '0;
        end else begin
          if (rdy[0]) begin
            v[0] <= in_valid;
            d[0] <= in_valid ? f : '0;
          end
          for (int s = 1; s < DEPTH; s++) begin
            if (rdy[s]) begin
              v[s] <= v[s-1];
              d[s] <= d[s-1];
            end
          end
        end
      end

      assign X         = d[DEPTH-1];
      assign out_valid = v[DEPTH-1];
      assign in_ready  = rdy[0];
    end
  endgenerate

  assign fire = out_valid & out_ready;

  // clr takes effect first so a colliding beat is counted into the fresh state.
  always_comb begin
    acc_nxt  = (clr ? '0 : acc) | (fire ? X : '0);
    hit_base = clr ? '0 : hit_cnt;
    hit_nxt  = hit_base;
    if (fire && (|X) && !(&hit_base)) hit_nxt = hit_base + CW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc     <= '0;
      hit_cnt <= '0;
    end else begin
      acc     <= acc_nxt;
      hit_cnt <= hit_nxt;
    end
  end

endmodule

// File: tb/tb_scs8hd_o31a_pipe.sv
// Bench for scs8hd_o31a_pipe: a DEPTH=2 build and a DEPTH=0/CW=3 build share one stimulus stream,
// each checked every cycle against a queue-based reference plus directed literal expectations.
module tb_scs8hd_o31a_pipe;
  localparam int NCH = 4, NA = 3, DEPTH = 2, CW = 8, CW0 = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NCH*NA-1:0] A = '0;
  logic [NCH-1:0]    B1 = '0;
  logic              in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
  logic              in_ready, out_valid, in_ready0, out_valid0;
  logic [NCH-1:0]    X, acc, X0, acc0;
  logic [CW-1:0]     hit_cnt;
  logic [CW0-1:0]    hit_cnt0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  scs8hd_o31a_pipe #(.NCH(NCH), .NA(NA), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B1(B1), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .out_valid(out_valid), .out_ready(out_ready), .clr(clr), .acc(acc), .hit_cnt(hit_cnt));

  scs8hd_o31a_pipe #(.NCH(NCH), .NA(NA), .DEPTH(0), .CW(CW0)) dut0 (
    .CLK(CLK), .RESET(RESET), .A(A), .B1(B1), .in_valid(in_valid), .in_ready(in_ready0),
    .X(X0), .out_valid(out_valid0), .out_ready(out_ready), .clr(clr), .acc(acc0), .hit_cnt(hit_cnt0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH-1:0] model_x(input logic [NCH*NA-1:0] a, input logic [NCH-1:0] b);
    logic [NCH-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) r[c] = (((a >> (NA * c)) & 12'h7) != 0) && b[c];
    return r;
  endfunction

  // Reference: the pipeline is a FIFO of capacity DEPTH whose head becomes visible DEPTH cycles after acceptance.
  typedef struct packed { logic [NCH-1:0] x; int t; } beat_t;
  beat_t          q[$];
  int             cyc = 0;
  int             m_hit = 0, m0_hit = 0;
  logic [NCH-1:0] m_acc = '0, m0_acc = '0;

  always @(negedge CLK or posedge RESET) begin : cmp
    logic ev, er, fire_m, fire0;
    logic [NCH-1:0] xo, fx;
    if (RESET) begin
      q.delete();
      m_acc = '0; m_hit = 0; m0_acc = '0; m0_hit = 0;
    end else begin
      fx = model_x(A, B1);
      ev = (q.size() > 0) && ((cyc - q[0].t) >= DEPTH);
      er = (q.size() < DEPTH) || out_ready;
      xo = ev ? q[0].x : '0;
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) chk("X", 32'(X), 32'(xo));
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("acc", 32'(acc), 32'(m_acc));
      chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
      chk("d0_X", 32'(X0), 32'(fx));
      chk("d0_out_valid", 32'(out_valid0), 32'(in_valid));
      chk("d0_in_ready", 32'(in_ready0), 32'(out_ready));
      chk("d0_acc", 32'(acc0), 32'(m0_acc));
      chk("d0_hit_cnt", 32'(hit_cnt0), 32'(m0_hit));
      fire_m = ev && out_ready;
      fire0  = in_valid && out_ready;
      if (fire_m) void'(q.pop_front());
      if (in_valid && er) q.push_back(beat_t'{x: fx, t: cyc});
      if (clr) begin m_acc = '0; m_hit = 0; m0_acc = '0; m0_hit = 0; end
      if (fire_m) m_acc = m_acc | xo;
      if (fire_m && xo != 0 && m_hit < (1 << CW) - 1) m_hit++;
      if (fire0) m0_acc = m0_acc | fx;
      if (fire0 && fx != 0 && m0_hit < (1 << CW0) - 1) m0_hit++;
      cyc++;
    end
  end

  task automatic drive(input logic v, input logic [NCH*NA-1:0] a, input logic [NCH-1:0] b,
                       input logic ordy, input logic c);
    @(posedge CLK); #1;
    in_valid = v; A = a; B1 = b; out_ready = ordy; clr = c;
    @(negedge CLK);
  endtask

  initial begin
    logic [NCH-1:0] vals [5];
    logic [NCH-1:0] got [5];
    int idx, n;
    vals = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_X", 32'(X), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_hit", 32'(hit_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: one beat lands exactly DEPTH cycles later.
    drive(1, 12'h001, 4'hF, 1, 0); chk("lat_c0", 32'(out_valid), 32'd0);
    drive(0, 12'h000, 4'h0, 1, 0); chk("lat_c1", 32'(out_valid), 32'd0);
    drive(0, 12'h000, 4'h0, 1, 0); chk("lat_c2", 32'(out_valid), 32'd1);
    chk("lat_X", 32'(X), 32'h1);
    drive(0, 12'h000, 4'h0, 1, 0);
    chk("lat_acc", 32'(acc), 32'h1);
    chk("lat_hit", 32'(hit_cnt), 32'd1);

    // Channel-0 truth table sweep.
    drive(0, 12'h000, 4'h0, 1, 1);
    for (int i = 0; i < 16; i++) drive(1, {9'b0, 3'(i)}, {3'b0, 1'(i >> 3)}, 1, 0);
    repeat (3) drive(0, 12'h000, 4'h0, 1, 0);
    chk("sweep_hit", 32'(hit_cnt), 32'd7);
    chk("sweep_acc", 32'(acc), 32'h1);

    // Backpressure: fill while stalled, then stream in order.
    drive(0, 12'h000, 4'h0, 1, 1);
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 12'hFFF, vals[idx], 0, 0);
      if (in_ready) idx++;
      if (k >= 2) chk("bp_stall_X", 32'(X), 32'h1);
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      drive(idx < 5, 12'hFFF, (idx < 5) ? vals[idx] : 4'h0, 1, 0);
      if (out_valid && n < 5) begin got[n] = X; n++; end
      if (in_valid && in_ready) idx++;
    end
    chk("bp_count", 32'(n), 32'd5);
    for (int k = 0; k < 5; k++) chk("bp_order", 32'(got[k]), 32'(vals[k]));

    // clr colliding with a fire.
    drive(0, 12'h000, 4'h0, 1, 1);
    drive(1, 12'hFFF, 4'h2, 1, 0); drive(1, 12'hFFF, 4'h4, 1, 0); drive(1, 12'hFFF, 4'h6, 1, 0);
    drive(1, 12'hFFF, 4'h2, 1, 0); drive(1, 12'hFFF, 4'h4, 1, 0);
    repeat (3) drive(0, 12'h000, 4'h0, 1, 0);
    chk("col_pre_acc", 32'(acc), 32'h6);
    chk("col_pre_hit", 32'(hit_cnt), 32'd5);
    drive(1, 12'hFFF, 4'h8, 1, 0); drive(0, 12'h000, 4'h0, 1, 0);
    drive(0, 12'h000, 4'h0, 1, 1); chk("col_fire", 32'(out_valid), 32'd1);
    drive(0, 12'h000, 4'h0, 1, 0);
    chk("col_acc", 32'(acc), 32'h8);
    chk("col_hit", 32'(hit_cnt), 32'd1);
    drive(1, 12'hFFF, 4'h0, 1, 0); drive(0, 12'h000, 4'h0, 1, 0);
    drive(0, 12'h000, 4'h0, 1, 1); chk("col0_fire", 32'(out_valid), 32'd1);
    drive(0, 12'h000, 4'h0, 1, 0);
    chk("col0_acc", 32'(acc), 32'h0);
    chk("col0_hit", 32'(hit_cnt), 32'd0);

    // Saturation on the CW=3 build.
    drive(0, 12'h000, 4'h0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      drive(k < 9, 12'hFFF, 4'hF, 1, 0);
      chk("sat_hit", 32'(hit_cnt0), 32'((k < 7) ? k : 7));
    end

    // DEPTH=0 build is combinational.
    drive(1, 12'hFFF, 4'h5, 0, 0);
    chk("d0_valid_on", 32'(out_valid0), 32'd1);
    chk("d0_X_lit", 32'(X0), 32'h5);
    chk("d0_ready_off", 32'(in_ready0), 32'd0);
    drive(0, 12'hFFF, 4'h5, 1, 0);
    chk("d0_valid_off", 32'(out_valid0), 32'd0);
    repeat (3) drive(0, 12'h000, 4'h0, 1, 0);

    // Async reset with beats in flight.
    drive(1, 12'hFFF, 4'hF, 0, 0); drive(1, 12'hFFF, 4'hF, 0, 0);
    drive(0, 12'h000, 4'h0, 0, 0); chk("ar_pre_valid", 32'(out_valid), 32'd1);
    @(posedge CLK); #2 RESET = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_acc", 32'(acc), 32'd0);
    chk("ar_hit", 32'(hit_cnt), 32'd0);
    chk("ar_d0_hit", 32'(hit_cnt0), 32'd0);
    #1 RESET = 1'b0;
    repeat (4) drive(0, 12'h000, 4'h0, 1, 0);
    chk("ar_no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) != 0, 12'($urandom), 4'($urandom), ($urandom % 3) != 0, ($urandom % 1000) == 0);
    repeat (4) drive(0, 12'h000, 4'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
